// File: rtl/addsub_seq_ctrl_pkg.sv
// addsub_seq_ctrl shared types and constants.
// FSM encodings, display-mode codes and segment patterns for the board top.
package addsub_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GET_Y = 3'd1,
        S_EXEC  = 3'd2,
        S_RES   = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [1:0] DM_BLANK = 2'd0;
    localparam logic [1:0] DM_OPS   = 2'd1;
    localparam logic [1:0] DM_RES   = 2'd2;
    localparam logic [1:0] DM_ERR   = 2'd3;

    // Active-low gfedcba patterns for the "Erro" message
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_O     = 7'b0100011;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/addsub_seq_ctrl_if.sv
// Bundle between the sequencer and the shared addsub4bits datapath.
// master = sequencer side, slave = datapath side.
interface addsub_seq_ctrl_if;
    logic [3:0] as_a;
    logic [3:0] as_b;
    logic       as_sub;
    logic [3:0] as_s;
    logic       as_ov;

    modport master (
        output as_a, as_b, as_sub,
        input  as_s, as_ov
    );

    modport slave (
        input  as_a, as_b, as_sub,
        output as_s, as_ov
    );
endinterface

// File: rtl/addsub_seq_ctrl_sync_edge.sv
// Two-flop synchronizer with a registered one-cycle rising-edge pulse.
// The pulse is high in cycle k+2..k+3 for an input rising before edge k.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= d;
            s2    <= s1;
            s3    <= s2;
            pulse <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Operand/result sequencer for the shared 4-bit add/sub datapath,
// with accumulator chaining and a blinking error display.
module addsub_seq_ctrl
    import addsub_seq_ctrl_pkg::*;
#(
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enter,
    input  logic        clr,
    input  logic        op,
    input  logic [3:0]  operand,
    addsub_seq_ctrl_if.master dp,
    output logic [3:0]  disp_x,
    output logic [3:0]  disp_y,
    output logic [3:0]  disp_res,
    output logic [1:0]  disp_mode,
    output logic        err_on,
    output logic        busy
);

    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

    logic enter_p;
    logic clr_p;

    sync_edge u_sync_enter (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (enter),
        .pulse (enter_p)
    );

    sync_edge u_sync_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (clr),
        .pulse (clr_p)
    );

    state_t        state, state_n;
    logic [3:0]    x, x_n;
    logic [3:0]    y, y_n;
    logic [3:0]    res, res_n;
    logic          sub_r, sub_n;
    logic          ovf, ovf_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          blink, blink_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            x     <= '0;
            y     <= '0;
            res   <= '0;
            sub_r <= 1'b0;
            ovf   <= 1'b0;
            cnt   <= '0;
            blink <= 1'b0;
        end else begin
            state <= state_n;
            x     <= x_n;
            y     <= y_n;
            res   <= res_n;
            sub_r <= sub_n;
            ovf   <= ovf_n;
            cnt   <= cnt_n;
            blink <= blink_n;
        end
    end

    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        res_n   = res;
        sub_n   = sub_r;
        ovf_n   = ovf;
        if (clr_p) begin
            state_n = S_IDLE;
            x_n     = '0;
            y_n     = '0;
            res_n   = '0;
            sub_n   = 1'b0;
            ovf_n   = 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (enter_p) begin
                    x_n     = operand;
                    state_n = S_GET_Y;
                end
                S_GET_Y: if (enter_p) begin
                    y_n     = operand;
                    sub_n   = op;
                    state_n = S_EXEC;
                end
                S_EXEC: begin
                    res_n   = dp.as_s;
                    ovf_n   = dp.as_ov;
                    state_n = dp.as_ov ? S_ERR : S_RES;
                end
                S_RES: if (enter_p) begin
                    x_n     = res;
                    state_n = S_GET_Y;
                end
                S_ERR: if (enter_p) begin
                    state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Blink phase restarts lit with a zero count on every ERR entry
    always_comb begin
        cnt_n   = '0;
        blink_n = 1'b0;
        if (state_n == S_ERR) begin
            if (state != S_ERR) begin
                blink_n = 1'b1;
            end else if (cnt == CNT_MAX) begin
                blink_n = ~blink;
            end else begin
                cnt_n   = cnt + 1'b1;
                blink_n = blink;
            end
        end
    end

    always_comb begin
        disp_mode = DM_BLANK;
        unique case (1'b1)
            (state == S_GET_Y),
            (state == S_EXEC): disp_mode = DM_OPS;
            (state == S_RES):  disp_mode = DM_RES;
            (state == S_ERR):  disp_mode = DM_ERR;
            default:           disp_mode = DM_BLANK;
        endcase
    end

    assign busy      = (state == S_EXEC);
    assign err_on    = blink & ovf;
    assign dp.as_a   = x;
    assign dp.as_b   = y;
    assign dp.as_sub = sub_r;
    assign disp_x    = x;
    assign disp_y    = y;
    assign disp_res  = res;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed bench for addsub_seq_ctrl with a behavioural 4-bit add/sub datapath.
// Expected values are hand-computed two's-complement results.
module tb_addsub_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enter;
    logic       clr;
    logic       op;
    logic [3:0] operand;
    logic [3:0] disp_x;
    logic [3:0] disp_y;
    logic [3:0] disp_res;
    logic [1:0] disp_mode;
    logic       err_on;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int busy_cnt = 0;
    int b0;

    addsub_seq_ctrl_if dp ();

    addsub_seq_ctrl #(.BLINK_DIV(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enter     (enter),
        .clr       (clr),
        .op        (op),
        .operand   (operand),
        .dp        (dp.master),
        .disp_x    (disp_x),
        .disp_y    (disp_y),
        .disp_res  (disp_res),
        .disp_mode (disp_mode),
        .err_on    (err_on),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] dp_model(logic [3:0] a, logic [3:0] b,
                                            logic sub);
        logic [3:0] s;
        logic       v;
        if (sub) begin
            s = a - b;
            v = (a[3] != b[3]) && (s[3] != a[3]);
        end else begin
            s = a + b;
            v = (a[3] == b[3]) && (s[3] != a[3]);
        end
        return {v, s};
    endfunction

    logic [4:0] dp_out;
    assign dp_out   = dp_model(dp.as_a, dp.as_b, dp.as_sub);
    assign dp.as_s  = dp_out[3:0];
    assign dp.as_ov = dp_out[4];

    always @(negedge clk) if (busy) busy_cnt++;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(logic [3:0] v, logic o);
        @(negedge clk);
        operand = v;
        op      = o;
        enter   = 1'b1;
        repeat (4) @(negedge clk);
        enter = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        enter   = 1'b0;
        clr     = 1'b0;
        op      = 1'b0;
        operand = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_mode", disp_mode, 0);
        chk("rst_a", dp.as_a, 0);
        chk("rst_b", dp.as_b, 0);
        chk("rst_sub", dp.as_sub, 0);
        chk("rst_res", disp_res, 0);
        chk("rst_err", err_on, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 3 + 2
        press(4'd3, 1'b0);
        chk("add_x", disp_x, 3);
        chk("add_mode_ops", disp_mode, 1);
        b0 = busy_cnt;
        press(4'd2, 1'b0);
        chk("add_a", dp.as_a, 3);
        chk("add_b", dp.as_b, 2);
        chk("add_sub", dp.as_sub, 0);
        chk("add_busy_cycles", busy_cnt - b0, 1);
        chk("add_mode", disp_mode, 2);
        chk("add_res", disp_res, 5);
        chk("add_err", err_on, 0);

        // chain: 5 - 7 = -2
        press(4'd9, 1'b0);
        chk("chain_x", disp_x, 5);
        chk("chain_mode_ops", disp_mode, 1);
        press(4'd7, 1'b1);
        chk("chain_sub", dp.as_sub, 1);
        chk("chain_res", disp_res, 4'hE);
        chk("chain_mode", disp_mode, 2);

        // into GET_Y with x = -2, then clear and enter together
        press(4'd0, 1'b0);
        chk("cp_pre_x", disp_x, 4'hE);
        @(negedge clk);
        clr   = 1'b1;
        enter = 1'b1;
        repeat (2) @(negedge clk);
        clr   = 1'b0;
        enter = 1'b0;
        repeat (5) @(negedge clk);
        chk("cp_mode", disp_mode, 0);
        chk("cp_x", disp_x, 0);
        chk("cp_y", disp_y, 0);
        chk("cp_res", disp_res, 0);
        chk("cp_sub", dp.as_sub, 0);

        // overflow 7 + 1 with blink
        press(4'd7, 1'b0);
        @(negedge clk);
        operand = 4'd1;
        op      = 1'b0;
        enter   = 1'b1;
        repeat (2) @(negedge clk);
        enter = 1'b0;
        repeat (3) @(negedge clk);
        chk("ov_mode", disp_mode, 3);
        chk("ov_res", disp_res, 4'h8);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("ov_blink%0d", i), err_on, ((i / 4) % 2) == 0);
            @(negedge clk);
        end
        press(4'd0, 1'b0);
        chk("ov_exit_mode", disp_mode, 0);
        chk("ov_exit_err", err_on, 0);

        // held enter: one capture, 3 edges after the rise
        do_clear();
        operand = 4'd6;
        enter   = 1'b1;
        repeat (3) @(negedge clk);
        chk("hold_k2_mode", disp_mode, 0);
        chk("hold_k2_x", disp_x, 0);
        @(negedge clk);
        chk("hold_k3_mode", disp_mode, 1);
        chk("hold_k3_x", disp_x, 6);
        operand = 4'd9;
        repeat (96) @(negedge clk);
        chk("hold_end_mode", disp_mode, 1);
        chk("hold_end_x", disp_x, 6);
        chk("hold_end_y", disp_y, 0);
        enter = 1'b0;
        repeat (4) @(negedge clk);

        // async reset in EXEC: 4 + 1 must never be latched
        do_clear();
        press(4'd4, 1'b0);
        @(negedge clk);
        operand = 4'd1;
        enter   = 1'b1;
        repeat (2) @(negedge clk);
        enter = 1'b0;
        repeat (2) @(negedge clk);
        chk("ar_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_mode", disp_mode, 0);
        chk("ar_a", dp.as_a, 0);
        chk("ar_b", dp.as_b, 0);
        chk("ar_res", disp_res, 0);
        chk("ar_err", err_on, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("ar_post_res", disp_res, 0);
        chk("ar_post_mode", disp_mode, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
